// File: rtl/cpu_io_ctrl.sv
// Byte-I/O controller: RX FIFO toward the core's special registers and a
// TX sequencer that hands execute-stage write requests to the UART transmitter.
module cpu_io_ctrl #(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          ack,
  input  logic                          w_req,
  input  logic [7:0]                    w_data,
  input  logic                          intr_en,
  input  logic                          tx_busy,
  output logic                          irr,
  output logic [7:0]                    r_data,
  output logic                          intr_req,
  output logic                          w_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(RX_DEPTH):0]     rx_level,
  output logic                          rx_overrun,
  output logic                          tx_drop
);

  localparam int unsigned PW = $clog2(RX_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    START       = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } tx_state_e;

  logic [7:0]    mem [RX_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  tx_state_e     state;

  assign full  = (count == LW'(RX_DEPTH));
  assign empty = (count == '0);
  // A full FIFO still takes a new byte when the head is popped in the same cycle.
  assign push  = rx_valid & (~full | ack);
  assign pop   = ack & ~empty;

  // RX FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < int'(RX_DEPTH); i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wptr] <= rx_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (rx_valid && full && !ack) rx_overrun <= 1'b1;
    end
  end

  assign irr      = ~empty;
  assign r_data   = empty ? 8'h00 : mem[rptr];
  assign rx_level = count;
  assign intr_req = irr & intr_en;

  // TX sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_data <= 8'h00;
      tx_drop <= 1'b0;
    end else begin
      if (w_req && state != IDLE) tx_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (w_req) begin
            tx_data <= w_data;
            state   <= START;
          end
        end
        START:       if (!tx_busy) state <= WAIT_ACCEPT;
        WAIT_ACCEPT: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE:   if (!tx_busy) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // Strobe decoded from state so reset removes it without waiting for a clock.
  assign tx_start = (state == START) & ~tx_busy;
  assign w_busy   = (state != IDLE);

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Directed bench for cpu_io_ctrl: RX FIFO order/overrun/wrap, interrupt gating,
// TX handshake sequencing and asynchronous reset.
module tb_cpu_io_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ack;
  logic       w_req;
  logic [7:0] w_data;
  logic       intr_en;
  logic       tx_busy;
  logic       irr;
  logic [7:0] r_data;
  logic       intr_req;
  logic       w_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] rx_level;
  logic       rx_overrun;
  logic       tx_drop;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_io_ctrl #(.RX_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .ack       (ack),
    .w_req     (w_req),
    .w_data    (w_data),
    .intr_en   (intr_en),
    .tx_busy   (tx_busy),
    .irr       (irr),
    .r_data    (r_data),
    .intr_req  (intr_req),
    .w_busy    (w_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .rx_level  (rx_level),
    .rx_overrun(rx_overrun),
    .tx_drop   (tx_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after this are seen at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pop_byte();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irr"},      32'(irr),        32'h0);
    check({tag, "_r_data"},   32'(r_data),     32'h0);
    check({tag, "_intr_req"}, 32'(intr_req),   32'h0);
    check({tag, "_w_busy"},   32'(w_busy),     32'h0);
    check({tag, "_tx_start"}, 32'(tx_start),   32'h0);
    check({tag, "_tx_data"},  32'(tx_data),    32'h0);
    check({tag, "_rx_level"}, 32'(rx_level),   32'h0);
    check({tag, "_overrun"},  32'(rx_overrun), 32'h0);
    check({tag, "_tx_drop"},  32'(tx_drop),    32'h0);
  endtask

  initial begin
    int starts;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack = 1'b0;
    w_req = 1'b0; w_data = 8'h00; intr_en = 1'b1; tx_busy = 1'b0;
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Basic push/ack ordering
    push_byte(8'h41);
    push_byte(8'h42);
    check("two_irr",   32'(irr),      32'h1);
    check("two_head",  32'(r_data),   32'h41);
    check("two_level", 32'(rx_level), 32'h2);
    pop_byte();
    check("ack1_head", 32'(r_data),   32'h42);
    pop_byte();
    check("ack2_irr",  32'(irr),      32'h0);
    check("ack2_data", 32'(r_data),   32'h0);
    pop_byte();
    check("ack_empty_level", 32'(rx_level), 32'h0);

    // Overrun and pointer wrap over three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
      push_byte(8'h14);
      check($sformatf("ovr_flag_r%0d", r),  32'(rx_overrun), 32'h1);
      check($sformatf("ovr_level_r%0d", r), 32'(rx_level),   32'h4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ovr_rd_r%0d_%0d", r, i), 32'(r_data), 32'h10 + 32'(i));
        pop_byte();
      end
      check($sformatf("ovr_drained_r%0d", r), 32'(irr), 32'h0);
    end

    // Simultaneous push/ack while full, then while empty
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
    rx_valid = 1'b1; rx_data = 8'h55; ack = 1'b1;
    step();
    rx_valid = 1'b0; ack = 1'b0;
    check("full_both_level",   32'(rx_level),   32'h4);
    check("full_both_overrun", 32'(rx_overrun), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_both_rd%0d", i), 32'(r_data), 32'h21 + 32'(i));
      pop_byte();
    end
    check("full_both_last", 32'(r_data), 32'h55);
    pop_byte();
    rx_valid = 1'b1; rx_data = 8'h66; ack = 1'b1;
    step();
    rx_valid = 1'b0; ack = 1'b0;
    check("empty_both_level", 32'(rx_level), 32'h1);
    check("empty_both_data",  32'(r_data),   32'h66);
    pop_byte();

    // Interrupt gating
    intr_en = 1'b0;
    push_byte(8'h77);
    check("intr_masked", 32'(intr_req), 32'h0);
    intr_en = 1'b1;
    #1;
    check("intr_same_cycle", 32'(intr_req), 32'h1);
    pop_byte();
    check("intr_drained", 32'(intr_req), 32'h0);

    // Normal transmit with a dropped request during busy
    w_req = 1'b1; w_data = 8'hA5;
    step();
    w_req = 1'b0; w_data = 8'h00;
    check("tx_busy_set",  32'(w_busy),   32'h1);
    check("tx_start_set", 32'(tx_start), 32'h1);
    check("tx_data_lat",  32'(tx_data),  32'hA5);
    starts = 1;
    step();
    if (tx_start) starts++;
    tx_busy = 1'b1;
    w_req = 1'b1; w_data = 8'h5A;
    step();
    w_req = 1'b0; w_data = 8'h00;
    check("tx_drop_set",  32'(tx_drop), 32'h1);
    check("tx_data_keep", 32'(tx_data), 32'hA5);
    for (int i = 1; i < 10; i++) begin
      if (tx_start) starts++;
      step();
    end
    check("tx_busy_held", 32'(w_busy), 32'h1);
    check("tx_start_once", 32'(starts), 32'h1);
    tx_busy = 1'b0;
    #1;
    check("w_busy_lag", 32'(w_busy), 32'h1);
    step();
    check("w_busy_clear", 32'(w_busy), 32'h0);

    // START held off by tx_busy, then reset in WAIT_DONE
    push_byte(8'h99);
    tx_busy = 1'b1;
    w_req = 1'b1; w_data = 8'h3C;
    step();
    w_req = 1'b0; w_data = 8'h00;
    check("hold_w_busy", 32'(w_busy),   32'h1);
    check("hold_start0", 32'(tx_start), 32'h0);
    step();
    check("hold_start1", 32'(tx_start), 32'h0);
    tx_busy = 1'b0;
    #1;
    check("hold_release", 32'(tx_start), 32'h1);
    step();
    tx_busy = 1'b1;
    step();
    check("wd_w_busy", 32'(w_busy), 32'h1);
    check("wd_irr",    32'(irr),    32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    step();
    reset = 1'b0;
    tx_busy = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_io_ctrl.md
# cpu_io_ctrl

Byte-I/O controller between the CPU core and the UART RX/TX engines. It buffers received bytes in a small FIFO and presents the head byte to the core's special registers as `r_data`/`irr`. It sequences execute-stage write requests (`w_req`/`w_data`) into the UART transmitter and reports `w_busy` back to the core. It also raises the interrupt request the core samples when `intr_en` is set.

## Interface
- `RX_DEPTH`, default 4: RX FIFO entries; must be a power of 2 and ≥ 2.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high; all state is cleared immediately.
- `rx_valid` in 1: one-cycle pulse from the UART receiver; a byte is present.
- `rx_data` in 8: received byte, valid while `rx_valid`=1.
- `ack` in 1: execute stage consumed `r_data`; pops the FIFO head.
- `w_req` in 1: execute stage requests transmission of `w_data`.
- `w_data` in 8: byte to transmit, valid while `w_req`=1.
- `intr_en` in 1: core interrupt enable from the special registers.
- `tx_busy` in 1: UART transmitter is shifting a byte.
- `irr` out 1: the RX FIFO is non-empty.
- `r_data` out 8: byte at the FIFO head; 0 when the FIFO is empty.
- `intr_req` out 1: `irr & intr_en`, combinational from registered state.
- `w_busy` out 1: the TX sequencer is not in IDLE.
- `tx_start` out 1: one-cycle start strobe to the UART transmitter.
- `tx_data` out 8: latched transmit byte.
- `rx_level` out $clog2(RX_DEPTH)+1: FIFO occupancy.
- `rx_overrun` out 1: sticky flag; a received byte was dropped.
- `tx_drop` out 1: sticky flag; a `w_req` was ignored while busy.

## Operation
RX FIFO:
- Circular buffer with read/write pointers of $clog2(RX_DEPTH) bits; pointers wrap modulo RX_DEPTH.
- `rx_valid` and not full: write `rx_data` at wptr; wptr+1.
- `ack` and not empty: rptr+1.
- Full/empty are evaluated on the pre-edge count.
- Full with both `rx_valid` and `ack`: both are accepted; count is unchanged, no overrun.
- Empty with both `rx_valid` and `ack`: the push is accepted, the ack is ignored; count becomes 1.
- `rx_valid` while full and no `ack`: the byte is dropped and `rx_overrun` is set.
- `ack` while empty: no effect.
- `rx_overrun` and `tx_drop` clear only on reset.

TX sequencer, states IDLE, START, WAIT_ACCEPT, WAIT_DONE:
- IDLE: on `w_req`, latch `w_data` into `tx_data` and go to START.
- START: `tx_start`=1 while `tx_busy`=0, then go to WAIT_ACCEPT. If `tx_busy`=1, hold in START with `tx_start`=0.
- WAIT_ACCEPT: on `tx_busy`=1, go to WAIT_DONE.
- WAIT_DONE: on `tx_busy`=0, go to IDLE.
- `w_req` in any state other than IDLE: ignored, `tx_data` is unchanged, and `tx_drop` is set.
- `w_busy` = (state ≠ IDLE). `tx_start` is decoded from the state and `tx_busy`, so it is never high in any state other than START.

## Timing
- Reset values:
  - all pointers and counts are 0, and TX state is IDLE;
  - `irr`, `intr_req`, `w_busy`, `tx_start`, `rx_overrun` and `tx_drop` are all 0;
  - `r_data`=0, `tx_data`=0, `rx_level`=0.
- RX latency: `rx_valid` in cycle N gives `irr`=1, `r_data`=byte and `rx_level`+1 in cycle N+1.
- Ack latency: `ack` in cycle N gives the next head (or `irr`=0) in cycle N+1.
- `intr_req` follows `irr` and `intr_en` in the same cycle, with no added register.
- TX latency: `w_req` at N in IDLE gives `w_busy`=1 and `tx_start`=1 at N+1, provided `tx_busy`=0.
- `w_busy` returns to 0 one cycle after `tx_busy` falls in WAIT_DONE.
- The earliest next accepted `w_req` is the cycle in which `w_busy`=0.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, FIFO contents are discarded, and `tx_start` drops asynchronously.
- Pointer wrap: after RX_DEPTH pushes and pops, the pointers return to 0 with no gap in data order.

## Test plan
- Reset, then push 0x41, 0x42: `irr`=1, `r_data`=0x41, `rx_level`=2. Ack gives `r_data`=0x42; ack again gives `irr`=0, `r_data`=0.
- Fill 4 bytes (0x10..0x13), then a 5th byte 0x14: `rx_overrun`=1, `rx_level`=4, and reads return 0x10..0x13. Repeat 3 rounds to cover pointer wrap.
- While full, apply `rx_valid`=0x55 and `ack` in the same cycle: `rx_level` stays 4, `rx_overrun` stays 0, and 0x55 is read last. While empty, apply push and ack together: `rx_level`=1.
- `intr_en`=0 with data present: `intr_req`=0. Raise `intr_en`: `intr_req`=1 in the same cycle. Drain the FIFO: `intr_req`=0.
- `w_req` with 0xA5 and `tx_busy`=0: next cycle `w_busy`=1, `tx_start`=1 for exactly 1 cycle, `tx_data`=0xA5. Model `tx_busy` high for 10 cycles: `w_busy` falls 1 cycle after `tx_busy`. A second `w_req` (0x5A) during busy sets `tx_drop`=1 and leaves `tx_data`=0xA5.
- Hold `tx_busy`=1 on entry to START: `tx_start` stays 0 until `tx_busy`=0. Assert reset in WAIT_DONE: all outputs return to their reset values immediately.
